// File: rtl/fft_peak_detector.sv
// Peak detector for a serial 32-bin complex FFT stream: L1 magnitude per bin, running max per frame,
// peak report with a done pulse, and a valid-gap timeout that drops truncated frames.
module fft_peak_detector #(
  parameter int NB_DATA     = 12,
  parameter int NB_BIN      = 5,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic [2*NB_DATA-1:0]   i_din,
  output logic [NB_BIN-1:0]      o_peak_bin,
  output logic [NB_DATA:0]       o_peak_mag,
  output logic                   o_frame_done,
  output logic                   o_frame_err,
  output logic                   o_busy
);

  localparam int FFT_N  = 2 ** NB_BIN;
  localparam int NB_GAP = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  localparam logic [NB_BIN-1:0] LAST_BIN = NB_BIN'(FFT_N - 1);
  localparam logic [NB_GAP-1:0] GAP_LAST = NB_GAP'(GAP_TIMEOUT - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t              state_q, state_d;
  logic [NB_BIN-1:0]   bin_q;
  logic [NB_GAP-1:0]   gap_q;
  logic                accept;
  logic                sample_first, sample_last, timeout;
  logic [NB_BIN-1:0]   sample_bin;

  logic                s1_valid, s1_first, s1_last;
  logic [NB_BIN-1:0]   s1_bin;
  logic [NB_DATA-1:0]  s1_abs_re, s1_abs_im;

  logic                s2_valid, s2_first, s2_last;
  logic [NB_BIN-1:0]   s2_bin;
  logic [NB_DATA:0]    s2_mag;

  logic                max_valid, max_last;
  logic [NB_BIN-1:0]   max_bin;
  logic [NB_DATA:0]    max_mag;

  // Two's-complement magnitude; the most negative input maps exactly to 2^(NB_DATA-1) as unsigned.
  function automatic logic [NB_DATA-1:0] abs_val(input logic [NB_DATA-1:0] x);
    return x[NB_DATA-1] ? (~x + NB_DATA'(1)) : x;
  endfunction

  assign accept = i_enable & i_valid;
  assign o_busy = (state_q == ACCUM);

  // NOTE: every output of a combinational block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sample_first = 1'b0;
    sample_last  = 1'b0;
    sample_bin   = bin_q;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sample_first = 1'b1;
          sample_bin   = '0;
          state_d      = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (bin_q == LAST_BIN) begin
            sample_last = 1'b1;
            state_d     = IDLE;
          end
        end else if (i_enable && gap_q == GAP_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      gap_q   <= '0;
    end else if (i_enable) begin
      state_q <= state_d;
      if (accept) begin
        bin_q <= sample_bin + NB_BIN'(1);
        gap_q <= '0;
      end else if (state_q == IDLE || timeout) begin
        bin_q <= '0;
        gap_q <= '0;
      end else begin
        gap_q <= gap_q + NB_GAP'(1);
      end
    end
  end

  // NOTE: datapath registers are reset along with the flags; there is no memory here that would make that costly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid     <= 1'b0;
      s1_first     <= 1'b0;
      s1_last      <= 1'b0;
      s1_bin       <= '0;
      s1_abs_re    <= '0;
      s1_abs_im    <= '0;
      s2_valid     <= 1'b0;
      s2_first     <= 1'b0;
      s2_last      <= 1'b0;
      s2_bin       <= '0;
      s2_mag       <= '0;
      max_valid    <= 1'b0;
      max_last     <= 1'b0;
      max_bin      <= '0;
      max_mag      <= '0;
      o_peak_bin   <= '0;
      o_peak_mag   <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else if (i_enable) begin
      s1_valid  <= accept;
      s1_first  <= sample_first;
      s1_last   <= sample_last;
      s1_bin    <= sample_bin;
      s1_abs_re <= abs_val(i_din[2*NB_DATA-1:NB_DATA]);
      s1_abs_im <= abs_val(i_din[NB_DATA-1:0]);

      s2_valid <= s1_valid;
      s2_first <= s1_valid & s1_first;
      s2_last  <= s1_valid & s1_last;
      s2_bin   <= s1_bin;
      s2_mag   <= {1'b0, s1_abs_re} + {1'b0, s1_abs_im};

      // Strict compare keeps the lowest bin on ties; the first bin of a frame always reloads.
      max_last <= s2_valid & s2_last;
      if (timeout) begin
        max_valid <= 1'b0;
      end else if (s2_valid && (s2_first || !max_valid || s2_mag > max_mag)) begin
        max_valid <= 1'b1;
        max_bin   <= s2_bin;
        max_mag   <= s2_mag;
      end

      o_frame_done <= max_last;
      o_frame_err  <= timeout;
      if (max_last) begin
        o_peak_bin <= max_bin;
        o_peak_mag <= max_mag;
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detector.sv
// Scoreboard bench for fft_peak_detector: expected peaks/aborts are queued when frames are driven
// and checked (values and cycle of arrival) when the done/err pulses appear.
module tb_fft_peak_detector;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_valid = 1'b0;
  logic [23:0] i_din = '0;
  logic [4:0]  o_peak_bin;
  logic [12:0] o_peak_mag;
  logic        o_frame_done, o_frame_err, o_busy;

  fft_peak_detector #(.NB_DATA(12), .NB_BIN(5), .GAP_TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_valid(i_valid), .i_din(i_din),
    .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag),
    .o_frame_done(o_frame_done), .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        is_err;
    logic [4:0]  bin;
    logic [12:0] mag;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [23:0] frame_data[32];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [4:0]  model_bin = '0;
  logic [12:0] model_mag = '0;
  logic        prev_done = 1'b0, prev_err = 1'b0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulses are counted on their rising edge so a pulse held through a stall is consumed once.
  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_done = 1'b0;
      prev_err  = 1'b0;
    end else begin
      if (o_frame_done && o_frame_err) begin
        n_vec++; n_err++;
        $display("FAIL pulse_overlap: done and err both high at cycle %0d", cyc);
      end
      if ((o_frame_done && !prev_done) || (o_frame_err && !prev_err)) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse: done=%0b err=%0b at cycle %0d, none expected", o_frame_done, o_frame_err, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_frame_err !== mon_e.is_err || o_peak_bin !== mon_e.bin || o_peak_mag !== mon_e.mag || cyc != mon_e.cyc) begin
            n_err++;
            $display("FAIL scoreboard_pulse: got err=%0b bin=%0d mag=%0d cycle=%0d, want err=%0b bin=%0d mag=%0d cycle=%0d",
                     o_frame_err, o_peak_bin, o_peak_mag, cyc, mon_e.is_err, mon_e.bin, mon_e.mag, mon_e.cyc);
          end
        end
      end
      prev_done = o_frame_done;
      prev_err  = o_frame_err;
    end
  end

  task automatic drive(input logic en, input logic vld, input logic [23:0] d);
    i_enable = en;
    i_valid  = vld;
    i_din    = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 24'h0);
  endtask

  task automatic fill_zero();
    for (int b = 0; b < 32; b++) frame_data[b] = 24'h0;
  endtask

  task automatic fill_random();
    for (int b = 0; b < 32; b++) frame_data[b] = 24'($urandom);
  endtask

  // Reference peak: first strictly larger |re|+|im| wins, computed in plain integer arithmetic.
  task automatic push_done(input int done_cyc);
    exp_t e;
    int   best, bbin, re, im, mag;
    best = -1;
    bbin = 0;
    for (int b = 0; b < 32; b++) begin
      re  = int'($signed(frame_data[b][23:12]));
      im  = int'($signed(frame_data[b][11:0]));
      mag = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      if (mag > best) begin
        best = mag;
        bbin = b;
      end
    end
    e.is_err  = 1'b0;
    e.bin     = 5'(bbin);
    e.mag     = 13'(best);
    e.cyc     = done_cyc;
    model_bin = e.bin;
    model_mag = e.mag;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input int err_cyc);
    exp_t e;
    e.is_err = 1'b1;
    e.bin    = model_bin;
    e.mag    = model_mag;
    e.cyc    = err_cyc;
    exp_q.push_back(e);
  endtask

  // pause_enabled=1: enabled idle edges (gap); 0: i_enable low with valid held high (stall).
  task automatic send_frame(input int nsamp, input int pause_at, input int pause_len,
                            input bit pause_enabled, input int post_stall, output int last_edge);
    last_edge = 0;
    for (int b = 0; b < nsamp; b++) begin
      if (b == pause_at) begin
        for (int s = 0; s < pause_len; s++) begin
          if (pause_enabled) drive(1'b1, 1'b0, frame_data[b]);
          else               drive(1'b0, 1'b1, frame_data[b]);
        end
      end
      drive(1'b1, 1'b1, frame_data[b]);
      last_edge = cyc;
    end
    if (nsamp == 32) push_done(last_edge + 3 + post_stall);
    for (int s = 0; s < post_stall; s++) drive(1'b0, 1'b0, 24'h0);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) drive(1'b1, 1'b0, 24'h0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d expected pulses still pending, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_vec++;
    if (o_peak_bin !== 5'd0)   begin n_err++; $display("FAIL %s_peak_bin: got %0d want 0", tag, o_peak_bin); end
    n_vec++;
    if (o_peak_mag !== 13'd0)  begin n_err++; $display("FAIL %s_peak_mag: got %0d want 0", tag, o_peak_mag); end
    n_vec++;
    if (o_frame_done !== 1'b0) begin n_err++; $display("FAIL %s_done: got %0b want 0", tag, o_frame_done); end
    n_vec++;
    if (o_frame_err !== 1'b0)  begin n_err++; $display("FAIL %s_err: got %0b want 0", tag, o_frame_err); end
    n_vec++;
    if (o_busy !== 1'b0)       begin n_err++; $display("FAIL %s_busy: got %0b want 0", tag, o_busy); end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 24'h0);
    i_rst = 1'b0;
    check_zero_outputs("reset");
  endtask

  task automatic test_impulse();
    int last;
    fill_zero();
    frame_data[13] = {12'hF9C, 12'h032};  // re=-100, im=50
    send_frame(32, -1, 0, 1'b0, 0, last);
    wait_drain(12);
  endtask

  task automatic test_extremes();
    int last;
    fill_zero();
    frame_data[4]  = {12'h800, 12'h800};
    frame_data[20] = {12'h800, 12'h800};
    send_frame(32, -1, 0, 1'b0, 0, last);
    fill_zero();
    send_frame(32, -1, 0, 1'b0, 0, last);
    wait_drain(12);
  endtask

  task automatic test_back_to_back();
    int last;
    fill_zero();
    frame_data[7] = {12'h0C8, 12'hF9C};   // 200, -100
    send_frame(32, -1, 0, 1'b0, 0, last);
    for (int b = 0; b < 32; b++) frame_data[b] = {12'(b % 8), 12'h000};
    frame_data[30] = {12'hFEC, 12'h014};  // -20, 20
    send_frame(32, -1, 0, 1'b0, 0, last);
    wait_drain(12);
  endtask

  task automatic test_gap_abort();
    int last;
    fill_random();
    send_frame(10, -1, 0, 1'b0, 0, last);
    push_err(last + 8);
    n_vec++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_mid: got %0b want 1", o_busy); end
    idle(7);
    n_vec++;
    if (o_busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_gap7: got %0b want 1", o_busy); end
    idle(1);
    n_vec++;
    if (o_busy !== 1'b0) begin n_err++; $display("FAIL abort_busy_after: got %0b want 0", o_busy); end
    wait_drain(6);
    fill_random();
    send_frame(32, -1, 0, 1'b0, 0, last);
    wait_drain(12);
    fill_random();
    send_frame(32, 10, 7, 1'b1, 0, last);  // one idle edge short of the timeout
    wait_drain(12);
  endtask

  task automatic test_stall();
    int last;
    int waited;
    fill_random();
    send_frame(32, -1, 0, 1'b0, 0, last);
    wait_drain(12);
    send_frame(32, 15, 5, 1'b0, 5, last);
    wait_drain(12);
    fill_random();
    send_frame(32, -1, 0, 1'b0, 0, last);
    waited = 0;
    while (!o_frame_done && waited < 10) begin
      drive(1'b1, 1'b0, 24'h0);
      waited++;
    end
    drive(1'b0, 1'b0, 24'h0);
    drive(1'b0, 1'b0, 24'h0);
    n_vec++;
    if (o_frame_done !== 1'b1) begin n_err++; $display("FAIL stall_hold_done: got %0b want 1", o_frame_done); end
    drive(1'b1, 1'b0, 24'h0);
    n_vec++;
    if (o_frame_done !== 1'b0) begin n_err++; $display("FAIL stall_release_done: got %0b want 0", o_frame_done); end
    wait_drain(4);
  endtask

  task automatic test_reset_mid();
    int last;
    fill_random();
    send_frame(21, -1, 0, 1'b0, 0, last);  // bins 0..20 accepted
    i_rst = 1'b1;
    drive(1'b1, 1'b0, 24'h0);
    drive(1'b1, 1'b0, 24'h0);
    i_rst = 1'b0;
    check_zero_outputs("reset_mid");
    model_bin = '0;
    model_mag = '0;
    idle(12);
    fill_random();
    send_frame(32, -1, 0, 1'b0, 0, last);
    wait_drain(12);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_extremes();
    test_back_to_back();
    test_gap_abort();
    test_stall();
    test_reset_mid();
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
